// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arbiter
// Description : Round-robin arbiter sharing one SPI master (spi_master_ss)
//               between NUM_REQ requesters. Sequences the master's
//               arm / finished / ready_to_arm handshake for the granted
//               requester and returns the received word with a one-cycle
//               done pulse.
//               Optional macro SPI_ARB_TIMEOUT_EN adds an ARM-state watchdog
//               that aborts a transfer the master never finishes (err=1).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_LEN     = 2,
    parameter int WID         = 24,
    parameter int TIMEOUT_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*WID-1:0] to_slave_in,
    output logic [NUM_REQ-1:0]     done,
    output logic [WID-1:0]         from_slave_out,
    output logic                   err,
    output logic                   busy,
    output logic [REQ_LEN-1:0]     grant_idx,
    output logic                   spi_arm,
    output logic [WID-1:0]         spi_to_slave,
    input  logic [WID-1:0]         spi_from_slave,
    input  logic                   spi_finished,
    input  logic                   spi_ready_to_arm
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [REQ_LEN-1:0]   last_grant;
    logic [REQ_LEN-1:0]   last_next;
    logic [REQ_LEN-1:0]   grant_next;
    logic                 busy_next;
    logic                 arm_next;
    logic [NUM_REQ-1:0]   done_next;
    logic [WID-1:0]       tx_next;
    logic [WID-1:0]       rx_next;

    logic [REQ_LEN-1:0]   winner;
    logic                 found;
    int                   cand;
    logic [REQ_LEN-1:0]   cand_idx;

    logic [WID-1:0]       tx_word [NUM_REQ];

    // Catch inconsistent parameterisation at elaboration time.
    generate
        if (NUM_REQ > 1 && REQ_LEN != $clog2(NUM_REQ)) begin : g_bad_req_len
            $error("spi_master_arbiter: REQ_LEN must equal clog2(NUM_REQ)");
        end
        if (TIMEOUT_LEN < 1) begin : g_bad_timeout_len
            $error("spi_master_arbiter: TIMEOUT_LEN must be at least 1");
        end
    endgenerate

    // Split the flat transmit bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tx_word[gi] = to_slave_in[gi*WID +: WID];
        end
    endgenerate

`ifdef SPI_ARB_TIMEOUT_EN
    // Abort fires on the cycle the counter would reach all-ones.
    localparam logic [TIMEOUT_LEN-1:0] TMO_LAST = ~TIMEOUT_LEN'(1);

    logic [TIMEOUT_LEN-1:0] tmo_cnt;
    logic                   tmo_hit;
    logic                   err_next;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Watchdog: held at zero outside ARM, counts every ARM cycle.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            tmo_cnt <= '0;
        end else if (state != ST_ARM) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_LEN'(1);
        end
    end

    // Error flag is a registered pulse aligned with done.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Round-robin search: first set req bit strictly after the last grant.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[REQ_LEN-1:0];
            if (!found && req[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        state_next = state;
        last_next  = last_grant;
        grant_next = grant_idx;
        busy_next  = busy;
        arm_next   = spi_arm;
        done_next  = '0;
        tx_next    = spi_to_slave;
        rx_next    = from_slave_out;
`ifdef SPI_ARB_TIMEOUT_EN
        err_next   = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (spi_ready_to_arm && found) begin
                    grant_next = winner;
                    tx_next    = tx_word[winner];
                    busy_next  = 1'b1;
                    arm_next   = 1'b1;
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                // finished takes priority over a simultaneous watchdog expiry
                if (spi_finished) begin
                    rx_next              = spi_from_slave;
                    done_next[grant_idx] = 1'b1;
                    arm_next             = 1'b0;
                    state_next           = ST_RELEASE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    done_next[grant_idx] = 1'b1;
                    err_next             = 1'b1;
                    arm_next             = 1'b0;
                    state_next           = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                arm_next = 1'b0;
                // last pointer moves only now, so a held req queues behind others
                if (spi_ready_to_arm) begin
                    last_next  = grant_idx;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                arm_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; last pointer resets so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state          <= ST_IDLE;
            last_grant     <= REQ_LEN'(NUM_REQ - 1);
            grant_idx      <= '0;
            busy           <= 1'b0;
            spi_arm        <= 1'b0;
            done           <= '0;
            spi_to_slave   <= '0;
            from_slave_out <= '0;
        end else begin
            state          <= state_next;
            last_grant     <= last_next;
            grant_idx      <= grant_next;
            busy           <= busy_next;
            spi_arm        <= arm_next;
            done           <= done_next;
            spi_to_slave   <= tx_next;
            from_slave_out <= rx_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arbiter
// Description : Directed self-checking bench for spi_master_arbiter with a
//               behavioural loopback SPI master. Define SPI_ARB_TIMEOUT_EN to
//               also exercise the watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

    localparam int NR = 4;
    localparam int RL = 2;
    localparam int W  = 24;
    localparam int TL = 4;

    logic            clk = 1'b0;
    logic            rst_L = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] to_slave_in = '0;
    logic [NR-1:0]   done;
    logic [W-1:0]    from_slave_out;
    logic            err;
    logic            busy;
    logic [RL-1:0]   grant_idx;
    logic            spi_arm;
    logic [W-1:0]    spi_to_slave;
    logic [W-1:0]    spi_from_slave;
    logic            spi_finished;
    logic            spi_ready_to_arm;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] words [NR];

    // behavioural master controls
    bit           m_hang = 1'b0;
    bit           m_kick = 1'b0;
    int           m_st;
    int           m_cnt;
    logic [W-1:0] m_shift;

    always #5 clk = ~clk;

    spi_master_arbiter #(
        .NUM_REQ     (NR),
        .REQ_LEN     (RL),
        .WID         (W),
        .TIMEOUT_LEN (TL)
    ) dut (
        .clk              (clk),
        .rst_L            (rst_L),
        .req              (req),
        .to_slave_in      (to_slave_in),
        .done             (done),
        .from_slave_out   (from_slave_out),
        .err              (err),
        .busy             (busy),
        .grant_idx        (grant_idx),
        .spi_arm          (spi_arm),
        .spi_to_slave     (spi_to_slave),
        .spi_from_slave   (spi_from_slave),
        .spi_finished     (spi_finished),
        .spi_ready_to_arm (spi_ready_to_arm)
    );

    // Loopback master: capture on arm, finish after a few cycles, hold
    // finished until arm drops, then become ready again.
    always @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            m_st             <= 0;
            m_cnt            <= 0;
            m_shift          <= '0;
            spi_ready_to_arm <= 1'b1;
            spi_finished     <= 1'b0;
            spi_from_slave   <= '0;
        end else begin
            case (m_st)
                0: if (spi_arm) begin
                    m_st             <= 1;
                    m_cnt            <= 3;
                    m_shift          <= spi_to_slave;
                    spi_ready_to_arm <= 1'b0;
                end
                1: if (!spi_arm) begin
                    if (m_kick) begin
                        m_st             <= 0;
                        spi_ready_to_arm <= 1'b1;
                    end
                end else if (!m_hang) begin
                    if (m_cnt == 0) begin
                        spi_finished   <= 1'b1;
                        spi_from_slave <= m_shift;
                        m_st           <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: if (!spi_arm) begin
                    spi_finished     <= 1'b0;
                    spi_ready_to_arm <= 1'b1;
                    m_st             <= 0;
                end
            endcase
        end
    end

    task automatic do_reset();
        rst_L = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_arm(output bit ok);
        int n = 0;
        while (!spi_arm && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = spi_arm;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (done != '0);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        checks++; if (spi_arm !== 1'b0) begin failures++; $display("FAIL reset_arm: got %b want 0", spi_arm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
        checks++; if (spi_to_slave !== 24'h0) begin failures++; $display("FAIL reset_to_slave: got %h want 000000", spi_to_slave); end
        checks++; if (from_slave_out !== 24'h0) begin failures++; $display("FAIL reset_from_slave: got %h want 000000", from_slave_out); end
        rst_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        to_slave_in[0 +: W] = 24'hA5F00F;
        req = 4'b0001;
        @(negedge clk);
        checks++; if (spi_arm !== 1'b1) begin failures++; $display("FAIL single_arm_latency: got %b want 1", spi_arm); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d want 0", grant_idx); end
        checks++; if (spi_to_slave !== 24'hA5F00F) begin failures++; $display("FAIL single_to_slave: got %h want a5f00f", spi_to_slave); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done_wait: got timeout want done"); end
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL single_done: got %b want 0001", done); end
        checks++; if (from_slave_out !== 24'hA5F00F) begin failures++; $display("FAIL single_rx: got %h want a5f00f", from_slave_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b want 0", err); end
        req = '0;
        @(negedge clk);
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_pulse: got %b want 0000", done); end
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_idle: got busy want idle"); end
    endtask

    task automatic test_contention();
        bit ok;
        logic [RL-1:0] exp;
        do_reset();
        for (int i = 0; i < NR; i++) to_slave_in[i*W +: W] = words[i];
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = RL'(n % NR);
            wait_arm(ok);
            checks++; if (!ok) begin failures++; $display("FAIL cont_arm_wait[%0d]: got timeout want arm", n); end
            checks++; if (grant_idx !== exp) begin failures++; $display("FAIL cont_grant[%0d]: got %0d want %0d", n, grant_idx, exp); end
            checks++; if (spi_to_slave !== words[exp]) begin failures++; $display("FAIL cont_to_slave[%0d]: got %h want %h", n, spi_to_slave, words[exp]); end
            wait_done(ok);
            checks++; if (done !== (NR'(1) << exp)) begin failures++; $display("FAIL cont_done[%0d]: got %b want %b", n, done, NR'(1) << exp); end
            checks++; if (from_slave_out !== words[exp]) begin failures++; $display("FAIL cont_rx[%0d]: got %h want %h", n, from_slave_out, words[exp]); end
            @(negedge clk);
        end
        req = '0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_idle: got busy want idle"); end
    endtask

    task automatic test_rotation();
        bit ok;
        do_reset();
        req = 4'b0100;
        wait_arm(ok);
        checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL rot_prime: got %0d want 2", grant_idx); end
        wait_done(ok);
        req = '0;
        wait_idle(ok);
        req = 4'b0101;
        wait_arm(ok);
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL rot_wrap: got %0d want 0", grant_idx); end
        checks++; if (spi_to_slave !== words[0]) begin failures++; $display("FAIL rot_wrap_data: got %h want %h", spi_to_slave, words[0]); end
        wait_done(ok);
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL rot_wrap_done: got %b want 0001", done); end
        req = 4'b0100;
        wait_arm(ok);
        checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL rot_second: got %0d want 2", grant_idx); end
        wait_done(ok);
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL rot_second_done: got %b want 0100", done); end
        req = '0;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        req = 4'b0010;
        wait_arm(ok);
        checks++; if (grant_idx !== 2'd1) begin failures++; $display("FAIL rmid_pre_grant: got %0d want 1", grant_idx); end
        #2 rst_L = 1'b0;
        #1;
        checks++; if (spi_arm !== 1'b0) begin failures++; $display("FAIL rmid_arm: got %b want 0", spi_arm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rmid_done: got %b want 0000", done); end
        checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL rmid_grant: got %0d want 0", grant_idx); end
        req = '0;
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        req = 4'b1000;
        wait_arm(ok);
        checks++; if (grant_idx !== 2'd3) begin failures++; $display("FAIL rmid_next_grant: got %0d want 3", grant_idx); end
        checks++; if (spi_to_slave !== words[3]) begin failures++; $display("FAIL rmid_next_data: got %h want %h", spi_to_slave, words[3]); end
        wait_done(ok);
        checks++; if (done !== 4'b1000) begin failures++; $display("FAIL rmid_next_done: got %b want 1000", done); end
        checks++; if (from_slave_out !== words[3]) begin failures++; $display("FAIL rmid_next_rx: got %h want %h", from_slave_out, words[3]); end
        req = '0;
        wait_idle(ok);
    endtask

    task automatic test_drop();
        bit ok;
        int arm_seen = 0;
        do_reset();
        req = 4'b0010;
        wait_arm(ok);
        @(negedge clk);
        req = '0;
        wait_done(ok);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL drop_done: got %b want 0010", done); end
        checks++; if (from_slave_out !== words[1]) begin failures++; $display("FAIL drop_rx: got %h want %h", from_slave_out, words[1]); end
        wait_idle(ok);
        repeat (10) begin
            @(negedge clk);
            if (spi_arm) arm_seen++;
        end
        checks++; if (arm_seen !== 0) begin failures++; $display("FAIL drop_regrant: got %0d arm cycles want 0", arm_seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy: got %b want 0", busy); end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n = 0;
        do_reset();
        req = 4'b0001;
        wait_done(ok);
        req = '0;
        wait_idle(ok);
        m_hang = 1'b1;
        req    = 4'b0010;
        wait_arm(ok);
        while (spi_arm && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 15) begin failures++; $display("FAIL tmo_arm_cycles: got %0d want 15", n); end
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL tmo_done: got %b want 0010", done); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b want 1", err); end
        checks++; if (from_slave_out !== words[0]) begin failures++; $display("FAIL tmo_rx_held: got %h want %h", from_slave_out, words[0]); end
        req = '0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse: got %b want 0", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_release_busy: got %b want 1", busy); end
        m_kick = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL tmo_idle: got busy want idle"); end
        m_kick = 1'b0;
        m_hang = 1'b0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        words[0] = 24'h111111;
        words[1] = 24'h222222;
        words[2] = 24'h333333;
        words[3] = 24'h444444;
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_reset_mid();
        test_drop();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
